// File: rtl/key_reverse_lookup_if.sv
// Bundle of the write, request and response channels of the reverse lookup table.
// The master side programs entries and issues lookups; the slave side is the table.
interface key_reverse_lookup_if #(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 3,
   parameter int DATA_LEN = 8,
   parameter int IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
);
   // Table programming
   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;
   logic [KEY_LEN-1:0]  wr_key;
   logic [DATA_LEN-1:0] wr_data;
   logic                clr;

   // Lookup request
   logic                req_valid;
   logic                req_ready;
   logic [DATA_LEN-1:0] req_data;

   // Lookup response
   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_hit;
   logic [KEY_LEN-1:0]  rsp_key;
   logic [IDX_W-1:0]    rsp_idx;

   modport master (
      output wr_en, wr_idx, wr_key, wr_data, clr,
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_key, rsp_idx
   );

   modport slave (
      input  wr_en, wr_idx, wr_key, wr_data, clr,
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_key, rsp_idx
   );
endinterface

// File: rtl/key_reverse_lookup.sv
// Reverse (data -> key) lookup table for the NPC decode path.
// NR_KEY programmable {key,data} entries; a lookup walks the entries one per cycle
// from index 0 and answers with the key of the first valid entry whose data matches,
// stopping early on a hit. A miss returns DEFAULT_KEY after the last entry.
module key_reverse_lookup #(
   parameter int                  NR_KEY      = 4,
   parameter int                  KEY_LEN     = 3,
   parameter int                  DATA_LEN    = 8,
   parameter logic [KEY_LEN-1:0]  DEFAULT_KEY = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   key_reverse_lookup_if.slave   bus
);

   localparam int               IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   // Table storage: valid bits are control, key/data are plain storage
   logic [NR_KEY-1:0]   ent_vld;
   logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
   logic [DATA_LEN-1:0] ent_data [NR_KEY];

   // Scan context
   logic [DATA_LEN-1:0] srch_data;
   logic [DATA_LEN-1:0] srch_data_nxt;
   logic [IDX_W-1:0]    scan_idx;
   logic [IDX_W-1:0]    scan_idx_nxt;
   logic                scan_hit;

   // Registered response
   logic                rsp_hit_q;
   logic                rsp_hit_nxt;
   logic [KEY_LEN-1:0]  rsp_key_q;
   logic [KEY_LEN-1:0]  rsp_key_nxt;
   logic [IDX_W-1:0]    rsp_idx_q;
   logic [IDX_W-1:0]    rsp_idx_nxt;

   logic                wr_in_range;
   logic                wr_commit;

   // Exact match over the full data width; an invalid entry never matches.
   function automatic logic entry_hit(input logic                vld,
                                      input logic [DATA_LEN-1:0] ent,
                                      input logic [DATA_LEN-1:0] srch);
      return vld && (ent == srch);
   endfunction

   // Out-of-range indices are dropped; clr takes priority over a same-cycle write.
   assign wr_in_range = (32'(bus.wr_idx) < NR_KEY);
   assign wr_commit   = bus.wr_en && wr_in_range && !bus.clr;

   // The compare sees the table as it stands before this edge's write/clear.
   assign scan_hit = entry_hit(ent_vld[scan_idx], ent_data[scan_idx], srch_data);

   // Valid bits: cleared by reset or clr, set by any accepted write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_vld <= '0;
      end else if (bus.clr) begin
         ent_vld <= '0;
      end else if (wr_commit) begin
         ent_vld[bus.wr_idx] <= 1'b1;
      end
   end

   // Entry contents: written in any FSM state, no reset needed behind the valid bit.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         ent_key[bus.wr_idx]  <= bus.wr_key;
         ent_data[bus.wr_idx] <= bus.wr_data;
      end
   end

   // Search value captured on request acceptance only.
   always_ff @(posedge clk) begin
      srch_data <= srch_data_nxt;
   end

   // FSM state, scan index and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         scan_idx  <= '0;
         rsp_hit_q <= 1'b0;
         rsp_key_q <= DEFAULT_KEY;
         rsp_idx_q <= '0;
      end else begin
         state     <= state_nxt;
         scan_idx  <= scan_idx_nxt;
         rsp_hit_q <= rsp_hit_nxt;
         rsp_key_q <= rsp_key_nxt;
         rsp_idx_q <= rsp_idx_nxt;
      end
   end

   // Next-state logic: accept in IDLE, walk entries in SCAN, hold the answer in RESP.
   always_comb begin
      state_nxt     = state;
      scan_idx_nxt  = scan_idx;
      srch_data_nxt = srch_data;
      rsp_hit_nxt   = rsp_hit_q;
      rsp_key_nxt   = rsp_key_q;
      rsp_idx_nxt   = rsp_idx_q;

      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               state_nxt     = SCAN;
               scan_idx_nxt  = '0;
               srch_data_nxt = bus.req_data;
            end
         end

         SCAN: begin
            if (scan_hit) begin
               state_nxt   = RESP;
               rsp_hit_nxt = 1'b1;
               rsp_key_nxt = ent_key[scan_idx];
               rsp_idx_nxt = scan_idx;
            end else if (scan_idx == LAST_IDX) begin
               state_nxt   = RESP;
               rsp_hit_nxt = 1'b0;
               rsp_key_nxt = DEFAULT_KEY;
               rsp_idx_nxt = '0;
            end else begin
               scan_idx_nxt = scan_idx + IDX_W'(1);
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.rsp_key   = rsp_key_q;
   assign bus.rsp_idx   = rsp_idx_q;

endmodule
